// File: rtl/axi_rd_pipe_ctrl.sv
// AXI4 read-channel register slice: skid-buffered AR/R stages, an outstanding-burst limiter and
// an R-beat reservation buffer sized so the memory side never sees R backpressure.
module axi_rd_pipe_ctrl #(
  parameter int unsigned ADDR_W          = 64,
  parameter int unsigned ID_W            = 1,
  parameter int unsigned DATA_W          = 512,
  parameter int unsigned AR_STAGES       = 2,
  parameter int unsigned R_STAGES        = 2,
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter int unsigned R_BUF_BEATS     = 64
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [ADDR_W-1:0]                    s_araddr,
  input  logic [ID_W-1:0]                      s_arid,
  input  logic [7:0]                           s_arlen,
  input  logic [2:0]                           s_arsize,
  input  logic [1:0]                           s_arburst,
  input  logic                                 s_arvalid,
  output logic                                 s_arready,
  output logic [DATA_W-1:0]                    s_rdata,
  output logic [ID_W-1:0]                      s_rid,
  output logic [1:0]                           s_rresp,
  output logic                                 s_rlast,
  output logic                                 s_rvalid,
  input  logic                                 s_rready,
  output logic [ADDR_W-1:0]                    m_araddr,
  output logic [ID_W-1:0]                      m_arid,
  output logic [7:0]                           m_arlen,
  output logic [2:0]                           m_arsize,
  output logic [1:0]                           m_arburst,
  output logic                                 m_arvalid,
  input  logic                                 m_arready,
  input  logic [DATA_W-1:0]                    m_rdata,
  input  logic [ID_W-1:0]                      m_rid,
  input  logic [1:0]                           m_rresp,
  input  logic                                 m_rlast,
  input  logic                                 m_rvalid,
  output logic                                 m_rready,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic [$clog2(R_BUF_BEATS+1)-1:0]     free_beats,
  output logic                                 err_unexp_r
);
  localparam int unsigned OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned FW  = $clog2(R_BUF_BEATS + 1);
  localparam int unsigned CW  = FW + 10;
  localparam int unsigned PW  = $clog2(R_BUF_BEATS);
  localparam int unsigned ArW = ADDR_W + ID_W + 13;
  localparam int unsigned RW  = DATA_W + ID_W + 3;

  logic           ar_v  [AR_STAGES+1];
  logic           ar_r  [AR_STAGES+1];
  logic [ArW-1:0] ar_pl [AR_STAGES+1];
  logic           r_v   [R_STAGES+1];
  logic           r_r   [R_STAGES+1];
  logic [RW-1:0]  r_pl  [R_STAGES+1];

  logic [8:0]    len_p1;
  logic          credit_ok, ar_fire, r_last_fire, m_fire, pop, full, empty;
  logic [OW-1:0] out_q, out_d;
  logic [FW-1:0] free_q, free_d, pend_q, pend_d;
  logic [CW-1:0] free_ext, pend_ext;
  logic [PW:0]   wr_q, wr_d, rd_q, rd_d;
  logic          err_q, err_d;
  logic [RW-1:0] mem [R_BUF_BEATS];

  // Reserve buffer space for the whole burst before it may leave towards memory.
  assign len_p1    = {1'b0, s_arlen} + 9'd1;
  assign credit_ok = (out_q < OW'(MAX_OUTSTANDING)) && (CW'(free_q) >= CW'(len_p1));
  assign ar_v[0]   = s_arvalid && credit_ok;
  assign ar_pl[0]  = {s_araddr, s_arid, s_arlen, s_arsize, s_arburst};
  assign s_arready = ar_r[0] && credit_ok;
  assign ar_fire   = s_arvalid && s_arready;

  assign ar_r[AR_STAGES] = m_arready;
  assign m_arvalid       = ar_v[AR_STAGES];
  assign {m_araddr, m_arid, m_arlen, m_arsize, m_arburst} = ar_pl[AR_STAGES];

  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign m_rready = !full;
  assign m_fire   = m_rvalid && !full;
  assign r_v[0]   = !empty;
  assign r_pl[0]  = mem[rd_q[PW-1:0]];
  assign pop      = !empty && r_r[0];

  assign r_r[R_STAGES] = s_rready;
  assign s_rvalid      = r_v[R_STAGES];
  assign {s_rdata, s_rid, s_rresp, s_rlast} = r_pl[R_STAGES];
  assign r_last_fire   = s_rvalid && s_rready && s_rlast;

  assign outstanding = out_q;
  assign free_beats  = free_q;
  assign err_unexp_r = err_q;

  for (genvar g = 0; g < AR_STAGES; g++) begin : g_ar_stage
    logic           v_q, v_d, sv_q, sv_d;
    logic [ArW-1:0] d_q, d_d, sd_q, sd_d;
    always_comb begin
      v_d = v_q; d_d = d_q; sv_d = sv_q; sd_d = sd_q;
      if (!v_q || ar_r[g+1]) begin
        v_d  = sv_q || ar_v[g];
        d_d  = sv_q ? sd_q : ar_pl[g];
        sv_d = 1'b0;
      end else if (ar_v[g] && !sv_q) begin
        sv_d = 1'b1;
        sd_d = ar_pl[g];
      end
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0; sv_q <= 1'b0; d_q <= '0; sd_q <= '0;
      end else begin
        v_q <= v_d; sv_q <= sv_d; d_q <= d_d; sd_q <= sd_d;
      end
    end
    assign ar_r[g]    = !sv_q;
    assign ar_v[g+1]  = v_q;
    assign ar_pl[g+1] = d_q;
  end

  for (genvar g = 0; g < R_STAGES; g++) begin : g_r_stage
    logic          v_q, v_d, sv_q, sv_d;
    logic [RW-1:0] d_q, d_d, sd_q, sd_d;
    always_comb begin
      v_d = v_q; d_d = d_q; sv_d = sv_q; sd_d = sd_q;
      if (!v_q || r_r[g+1]) begin
        v_d  = sv_q || r_v[g];
        d_d  = sv_q ? sd_q : r_pl[g];
        sv_d = 1'b0;
      end else if (r_v[g] && !sv_q) begin
        sv_d = 1'b1;
        sd_d = r_pl[g];
      end
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0; sv_q <= 1'b0; d_q <= '0; sd_q <= '0;
      end else begin
        v_q <= v_d; sv_q <= sv_d; d_q <= d_d; sd_q <= sd_d;
      end
    end
    assign r_r[g]    = !sv_q;
    assign r_v[g+1]  = v_q;
    assign r_pl[g+1] = d_q;
  end

  always_comb begin
    out_d = out_q;
    if (ar_fire && !r_last_fire) begin
      out_d = out_q + OW'(1);
    end else if (!ar_fire && r_last_fire) begin
      out_d = out_q - OW'(1);
    end
    free_ext = CW'(free_q) + CW'(pop) - (ar_fire ? CW'(len_p1) : CW'(0));
    free_d   = free_ext[FW-1:0];
    // Beats still expected from memory; a beat arriving with none expected is a protocol error.
    pend_ext = CW'(pend_q) + (ar_fire ? CW'(len_p1) : CW'(0)) - CW'(m_fire && (pend_q != '0));
    pend_d   = pend_ext[FW-1:0];
    err_d    = err_q || (m_fire && (pend_q == '0));
    wr_d     = wr_q + {{PW{1'b0}}, m_fire};
    rd_d     = rd_q + {{PW{1'b0}}, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      free_q <= FW'(R_BUF_BEATS);
      pend_q <= '0;
      err_q  <= 1'b0;
      wr_q   <= '0;
      rd_q   <= '0;
    end else begin
      out_q  <= out_d;
      free_q <= free_d;
      pend_q <= pend_d;
      err_q  <= err_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (m_fire) begin
      mem[wr_q[PW-1:0]] <= {m_rdata, m_rid, m_rresp, m_rlast};
    end
  end

  // Credit accounting is meaningless once an unexpected beat has been absorbed.
  a_free_bounds: assert property (@(posedge clk) disable iff (!rst_n || err_q)
    free_ext <= CW'(R_BUF_BEATS));
  a_pend_bounds: assert property (@(posedge clk) disable iff (!rst_n || err_q)
    pend_ext <= CW'(R_BUF_BEATS));
  a_out_underflow: assert property (@(posedge clk) disable iff (!rst_n || err_q)
    !(r_last_fire && !ar_fire && (out_q == '0)));
  a_out_overflow: assert property (@(posedge clk) disable iff (!rst_n || err_q)
    !(ar_fire && !r_last_fire && (out_q == OW'(MAX_OUTSTANDING))));

endmodule

// File: tb/tb_axi_rd_pipe_ctrl.sv
// Directed bench for axi_rd_pipe_ctrl: default instance plus a MAX_OUTSTANDING=2 instance.
module tb_axi_rd_pipe_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [63:0]  s_araddr;  logic [0:0] s_arid;  logic [7:0] s_arlen;
  logic [2:0]   s_arsize;  logic [1:0] s_arburst;  logic s_arvalid, s_arready;
  logic [511:0] s_rdata;   logic [0:0] s_rid;   logic [1:0] s_rresp;
  logic         s_rlast, s_rvalid, s_rready;
  logic [63:0]  m_araddr;  logic [0:0] m_arid;  logic [7:0] m_arlen;
  logic [2:0]   m_arsize;  logic [1:0] m_arburst;  logic m_arvalid, m_arready;
  logic [511:0] m_rdata;   logic [0:0] m_rid;   logic [1:0] m_rresp;
  logic         m_rlast, m_rvalid, m_rready;
  logic [4:0]   outstanding;  logic [6:0] free_beats;  logic err_unexp_r;

  logic [31:0] c_s_araddr;  logic [0:0] c_s_arid;  logic [7:0] c_s_arlen;
  logic [2:0]  c_s_arsize;  logic [1:0] c_s_arburst;  logic c_s_arvalid, c_s_arready;
  logic [31:0] c_s_rdata;   logic [0:0] c_s_rid;   logic [1:0] c_s_rresp;
  logic        c_s_rlast, c_s_rvalid, c_s_rready;
  logic [31:0] c_m_araddr;  logic [0:0] c_m_arid;  logic [7:0] c_m_arlen;
  logic [2:0]  c_m_arsize;  logic [1:0] c_m_arburst;  logic c_m_arvalid, c_m_arready;
  logic [31:0] c_m_rdata;   logic [0:0] c_m_rid;   logic [1:0] c_m_rresp;
  logic        c_m_rlast, c_m_rvalid, c_m_rready;
  logic [1:0]  c_outstanding;  logic [6:0] c_free_beats;  logic c_err_unexp_r;

  axi_rd_pipe_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rid(s_rid), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rid(m_rid), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .outstanding(outstanding), .free_beats(free_beats), .err_unexp_r(err_unexp_r)
  );

  axi_rd_pipe_ctrl #(.ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(2)) dut_cap (
    .clk(clk), .rst_n(rst_n),
    .s_araddr(c_s_araddr), .s_arid(c_s_arid), .s_arlen(c_s_arlen), .s_arsize(c_s_arsize),
    .s_arburst(c_s_arburst), .s_arvalid(c_s_arvalid), .s_arready(c_s_arready),
    .s_rdata(c_s_rdata), .s_rid(c_s_rid), .s_rresp(c_s_rresp), .s_rlast(c_s_rlast),
    .s_rvalid(c_s_rvalid), .s_rready(c_s_rready),
    .m_araddr(c_m_araddr), .m_arid(c_m_arid), .m_arlen(c_m_arlen), .m_arsize(c_m_arsize),
    .m_arburst(c_m_arburst), .m_arvalid(c_m_arvalid), .m_arready(c_m_arready),
    .m_rdata(c_m_rdata), .m_rid(c_m_rid), .m_rresp(c_m_rresp), .m_rlast(c_m_rlast),
    .m_rvalid(c_m_rvalid), .m_rready(c_m_rready),
    .outstanding(c_outstanding), .free_beats(c_free_beats), .err_unexp_r(c_err_unexp_r)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_araddr = '0; s_arid = '0; s_arlen = '0; s_arsize = 3'd6; s_arburst = 2'd1;
    s_arvalid = 1'b0; s_rready = 1'b0; m_arready = 1'b0;
    m_rdata = '0; m_rid = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
    c_s_araddr = '0; c_s_arid = '0; c_s_arlen = '0; c_s_arsize = 3'd2; c_s_arburst = 2'd1;
    c_s_arvalid = 1'b0; c_s_rready = 1'b0; c_m_arready = 1'b0;
    c_m_rdata = '0; c_m_rid = '0; c_m_rresp = '0; c_m_rlast = 1'b0; c_m_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (s_arready !== 1'b1) begin bad++; $display("FAIL rst_arready: got %b want 1", s_arready); end
    total++; if (m_arvalid !== 1'b0) begin bad++; $display("FAIL rst_arvalid: got %b want 0", m_arvalid); end
    total++; if (s_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid: got %b want 0", s_rvalid); end
    total++; if (free_beats !== 7'd64) begin bad++; $display("FAIL rst_free: got %0d want 64", free_beats); end
    total++; if (outstanding !== 5'd0) begin bad++; $display("FAIL rst_outst: got %0d want 0", outstanding); end
    total++; if (err_unexp_r !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err_unexp_r); end
  endtask

  task automatic test_ar_latency();
    int got;
    do_reset();
    m_arready = 1'b1; s_rready = 1'b1;
    s_araddr = 64'h1000; s_arid = 1'b1; s_arlen = 8'd7; s_arvalid = 1'b1;
    total++; if (s_arready !== 1'b1) begin bad++; $display("FAIL lat_arready: got %b want 1", s_arready); end
    step();
    s_arvalid = 1'b0;
    total++; if (free_beats !== 7'd56) begin bad++; $display("FAIL lat_free: got %0d want 56", free_beats); end
    total++; if (outstanding !== 5'd1) begin bad++; $display("FAIL lat_outst: got %0d want 1", outstanding); end
    total++; if (m_arvalid !== 1'b0) begin bad++; $display("FAIL lat_early: got %b want 0", m_arvalid); end
    step();
    total++; if (m_arvalid !== 1'b1) begin bad++; $display("FAIL lat_arvalid: got %b want 1", m_arvalid); end
    total++; if (m_araddr !== 64'h1000 || m_arlen !== 8'd7) begin
      bad++; $display("FAIL lat_arpayload: got %0h/%0d want 1000/7", m_araddr, m_arlen);
    end
    step();
    total++; if (m_arvalid !== 1'b0) begin bad++; $display("FAIL lat_drain: got %b want 0", m_arvalid); end
    got = 0;
    for (int c = 0; c < 30; c++) begin
      if (c < 8) begin
        m_rvalid = 1'b1; m_rid = 1'b1; m_rdata = 512'(c + 160); m_rlast = (c == 7);
        total++; if (m_rready !== 1'b1) begin bad++; $display("FAIL lat_rready: got %b want 1", m_rready); end
      end else begin
        m_rvalid = 1'b0; m_rlast = 1'b0;
      end
      if (s_rvalid === 1'b1) begin
        total++; if (s_rdata !== 512'(got + 160) || s_rlast !== (got == 7)) begin
          bad++; $display("FAIL lat_rbeat%0d: got %0h/%b want %0h/%b", got, s_rdata[15:0], s_rlast,
                          got + 160, got == 7);
        end
        got++;
      end
      step();
    end
    total++; if (got !== 8) begin bad++; $display("FAIL lat_count: got %0d want 8", got); end
    total++; if (outstanding !== 5'd0) begin bad++; $display("FAIL lat_outst_end: got %0d want 0", outstanding); end
    total++; if (free_beats !== 7'd64) begin bad++; $display("FAIL lat_free_end: got %0d want 64", free_beats); end
  endtask

  task automatic test_credit_stall();
    do_reset();
    m_arready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_arvalid = 1'b1; s_arlen = 8'd15; s_araddr = 64'(i * 256);
      total++; if (s_arready !== 1'b1) begin bad++; $display("FAIL cr_ar%0d: got %b want 1", i, s_arready); end
      step();
    end
    s_arlen = 8'd0;
    total++; if (free_beats !== 7'd0) begin bad++; $display("FAIL cr_free0: got %0d want 0", free_beats); end
    total++; if (outstanding !== 5'd4) begin bad++; $display("FAIL cr_outst4: got %0d want 4", outstanding); end
    for (int i = 0; i < 3; i++) begin
      total++; if (s_arready !== 1'b0) begin bad++; $display("FAIL cr_stall%0d: got %b want 0", i, s_arready); end
      step();
    end
    m_rvalid = 1'b1; m_rdata = 512'd5; m_rlast = 1'b0;
    step();
    m_rvalid = 1'b0;
    total++; if (s_arready !== 1'b0) begin bad++; $display("FAIL cr_inbuf: got %b want 0", s_arready); end
    step();
    total++; if (free_beats !== 7'd1) begin bad++; $display("FAIL cr_free1: got %0d want 1", free_beats); end
    total++; if (s_arready !== 1'b1) begin bad++; $display("FAIL cr_open: got %b want 1", s_arready); end
    step();
    s_arvalid = 1'b0;
    total++; if (outstanding !== 5'd5) begin bad++; $display("FAIL cr_outst5: got %0d want 5", outstanding); end
    total++; if (free_beats !== 7'd0) begin bad++; $display("FAIL cr_free_end: got %0d want 0", free_beats); end
  endtask

  task automatic test_outstanding_cap();
    int n;
    do_reset();
    c_m_arready = 1'b1; c_s_rready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      c_s_arvalid = 1'b1; c_s_arlen = 8'd0; c_s_araddr = 32'(i * 64);
      total++; if (c_s_arready !== 1'b1) begin bad++; $display("FAIL cap_ar%0d: got %b want 1", i, c_s_arready); end
      step();
    end
    c_s_araddr = 32'h80;
    total++; if (c_outstanding !== 2'd2) begin bad++; $display("FAIL cap_outst2: got %0d want 2", c_outstanding); end
    for (int i = 0; i < 3; i++) begin
      total++; if (c_s_arready !== 1'b0) begin bad++; $display("FAIL cap_held%0d: got %b want 0", i, c_s_arready); end
      step();
    end
    c_m_rvalid = 1'b1; c_m_rlast = 1'b1; c_m_rdata = 32'h77;
    step();
    c_m_rvalid = 1'b0; c_m_rlast = 1'b0;
    n = 0;
    while (c_s_rvalid !== 1'b1 && n < 10) begin
      total++; if (c_s_arready !== 1'b0) begin bad++; $display("FAIL cap_wait: got %b want 0", c_s_arready); end
      step();
      n++;
    end
    total++; if (c_s_rvalid !== 1'b1 || c_s_rdata !== 32'h77) begin
      bad++; $display("FAIL cap_rbeat: got %b/%0h want 1/77", c_s_rvalid, c_s_rdata);
    end
    total++; if (c_s_arready !== 1'b0) begin bad++; $display("FAIL cap_pre: got %b want 0", c_s_arready); end
    step();
    total++; if (c_outstanding !== 2'd1 || c_s_arready !== 1'b1) begin
      bad++; $display("FAIL cap_release: got %0d/%b want 1/1", c_outstanding, c_s_arready);
    end
    step();
    c_s_arvalid = 1'b0;
    total++; if (c_outstanding !== 2'd2) begin bad++; $display("FAIL cap_third: got %0d want 2", c_outstanding); end
  endtask

  task automatic test_backpressure();
    int got;
    int cyc;
    do_reset();
    m_arready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_arvalid = 1'b1; s_arlen = 8'd15; s_araddr = 64'(i * 1024);
      total++; if (s_arready !== 1'b1) begin bad++; $display("FAIL bp_ar%0d: got %b want 1", i, s_arready); end
      step();
    end
    s_arvalid = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (c < 64) begin
        m_rvalid = 1'b1; m_rdata = 512'(c); m_rlast = ((c % 16) == 15);
      end else begin
        m_rvalid = 1'b0; m_rlast = 1'b0;
      end
      total++; if (m_rready !== 1'b1) begin bad++; $display("FAIL bp_rready@%0d: got %b want 1", c, m_rready); end
      step();
    end
    s_rready = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 64 && cyc < 200) begin
      if (s_rvalid === 1'b1) begin
        total++; if (s_rdata !== 512'(got) || s_rlast !== ((got % 16) == 15)) begin
          bad++; $display("FAIL bp_order%0d: got %0h/%b want %0h/%b", got, s_rdata[15:0], s_rlast,
                          got, (got % 16) == 15);
        end
        got++;
      end
      step();
      cyc++;
    end
    total++; if (got !== 64) begin bad++; $display("FAIL bp_count: got %0d want 64", got); end
    total++; if (outstanding !== 5'd0) begin bad++; $display("FAIL bp_outst: got %0d want 0", outstanding); end
    total++; if (free_beats !== 7'd64) begin bad++; $display("FAIL bp_free: got %0d want 64", free_beats); end
  endtask

  task automatic test_unexp_r();
    do_reset();
    total++; if (err_unexp_r !== 1'b0) begin bad++; $display("FAIL ue_init: got %b want 0", err_unexp_r); end
    m_rvalid = 1'b1; m_rdata = 512'hdead; m_rlast = 1'b1;
    total++; if (m_rready !== 1'b1) begin bad++; $display("FAIL ue_rready: got %b want 1", m_rready); end
    step();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    total++; if (err_unexp_r !== 1'b1) begin bad++; $display("FAIL ue_set: got %b want 1", err_unexp_r); end
    repeat (5) step();
    total++; if (err_unexp_r !== 1'b1) begin bad++; $display("FAIL ue_sticky: got %b want 1", err_unexp_r); end
    rst_n = 1'b0;
    #1;
    total++; if (err_unexp_r !== 1'b0) begin bad++; $display("FAIL ue_clear: got %b want 0", err_unexp_r); end
    total++; if (s_rvalid !== 1'b0) begin bad++; $display("FAIL ue_rvalid: got %b want 0", s_rvalid); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    test_reset();
    test_ar_latency();
    test_credit_stall();
    test_outstanding_cap();
    test_backpressure();
    test_unexp_r();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
